// File: rtl/mult_share_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package mult_share_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} mult_share_state_t;
  localparam int MS_OPW = 4;
  localparam int MS_PW  = 8;
endpackage

// File: rtl/mult_share_rr_grant.sv
// Round-robin priority select: first valid requester searching upward from ptr+1.
// Purely combinational; gnt is one-hot or zero, gnt_idx is its encoded index.
module mult_share_rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk from lowest priority to highest so the nearest hit after ptr is written last.
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt                              = '0;
        gnt[(int'(ptr) + k) % NREQ]      = 1'b1;
        gnt_idx                          = IDW'((int'(ptr) + k) % NREQ);
        gnt_any                          = 1'b1;
      end
    end
  end
endmodule

// File: rtl/multiplier_4bit.sv
// Combinational unsigned 4x4 multiplier; full 8-bit product, no truncation.
module multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

// File: rtl/mult_share_arb.sv
// Shares one multiplier_4bit among NREQ requesters: grant, CALC, RESP (2 cycles grant to rsp_valid).
// rsp_* hold while rsp_ready is low and no new grant is issued; MULT_SHARE_ARB_STATS_EN adds grant_cnt.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][MS_OPW-1:0]  req_a,
  input  logic [NREQ-1:0][MS_OPW-1:0]  req_b,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDW-1:0]               rsp_id,
  output logic [MS_PW-1:0]             rsp_p,
  output logic                         busy
`ifdef MULT_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]                  grant_cnt
`endif
);
  mult_share_state_t state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [MS_OPW-1:0] a_q, a_d, b_q, b_d;
  logic [MS_PW-1:0]  rsp_p_q, rsp_p_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;
  logic [MS_PW-1:0]  prod;

  mult_share_rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  multiplier_4bit u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = req_a[gnt_idx];
          b_d     = req_b[gnt_idx];
          id_d    = gnt_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_p_d     = prod;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d       = id_q;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // Gated by rst so nothing looks accepted while the block is being cleared.
    req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  end

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (state_q == IDLE && gnt_any) grant_cnt_d = grant_cnt_q + 16'd1;
  end
  assign grant_cnt = grant_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULT_SHARE_ARB_STATS_EN
      grant_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef MULT_SHARE_ARB_STATS_EN
      grant_cnt_q <= grant_cnt_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
endmodule
